alu_seq_nbit: RTL

Parametrised, handshaked successor to the team's 8-bit combinational ALU, for datapaths that need N-bit width and back-pressure. Executes the same eight operations on `WIDTH`-bit operands and registers every result with status flags. Multiply is iterative shift-add and returns a full double-width product, so the block no longer needs a combinational multiplier. Sits between an operand-issue stage and a result-consuming stage, with valid/ready on both sides.

---
 rtl/alu_seq_nbit_pkg.sv | 33 +++
 rtl/alu_seq_nbit_mul_seq.sv | 60 ++++++
 rtl/alu_seq_nbit.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/alu_seq_nbit_pkg.sv
// Shared types for the handshaked N-bit ALU: opcodes, FSM states, status flags.
// Pure declarations, no logic or latency of its own.
// Not applicable to back-pressure; used by alu_seq_nbit and alu_mul_seq.
package alu_pkg;

   // Opcode encodings match the legacy 8-bit combinational ALU.
   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_MUL = 3'b101,
      OP_SHR = 3'b110,
      OP_SHL = 3'b111
   } alu_op_t;

   // Top-level sequencer: IDLE handles single-cycle ops, MUL waits on the multiplier.
   typedef enum logic {
      S_IDLE = 1'b0,
      S_MUL  = 1'b1
   } alu_state_t;

   typedef struct packed {
      logic cout;
      logic zero;
      logic neg;
      logic ovf;
   } alu_flags_t;

   localparam alu_flags_t FLAGS_CLR = '0;

endpackage

// File: rtl/alu_seq_nbit_mul_seq.sv
// Iterative shift-add unsigned multiplier, MSB-first, one partial product per cycle.
// Latency: WIDTH cycles of busy after start; done marks the final step, product valid with it.
// No back-pressure: start is only honoured while idle; the caller must consume product on done.
module alu_mul_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_nxt;
   logic [SHW-1:0]     cnt;
   logic [WIDTH-1:0]   pp;

   // One MSB-first step: double the accumulator and add A when the current B bit is set.
   // The counter doubles as the B bit index, so it walks WIDTH-1 down to 0.
   always_comb begin
      pp      = b_q[cnt] ? a_q : '0;
      acc_nxt = {acc[2*WIDTH-2:0], 1'b0} + {{WIDTH{1'b0}}, pp};
      done    = busy && (cnt == '0);
      product = acc_nxt;
   end

   // Operand capture on start, then one accumulate per cycle until the counter reaches 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q  <= '0;
         b_q  <= '0;
         acc  <= '0;
         cnt  <= '0;
         busy <= 1'b0;
      end else if (start && !busy) begin
         a_q  <= a;
         b_q  <= b;
         acc  <= '0;
         cnt  <= SHW'(WIDTH - 1);
         busy <= 1'b1;
      end else if (busy) begin
         acc <= acc_nxt;
         if (cnt == '0) begin
            busy <= 1'b0;
         end else begin
            cnt <= cnt - SHW'(1);
         end
      end
   end

endmodule

// File: rtl/alu_seq_nbit.sv
// N-bit eight-op ALU with registered result/flags and valid/ready on both sides.
// Latency: 1 cycle for single-cycle ops, WIDTH+1 cycles from accept for MUL.
// Holds result and flags while out_valid && !out_ready; in_ready low during MUL or a stalled result.
module alu_seq_nbit
   import alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       ALU_Sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Out,
   output logic [WIDTH-1:0] Out_hi,
   output logic             Cout,
   output logic             Zero,
   output logic             Neg,
   output logic             Ovf
);

   alu_state_t state;
   alu_state_t state_nxt;
   alu_op_t    op;

   logic accept;
   logic load_alu;
   logic load_mul;
   logic mul_start;
   logic mul_busy;
   logic mul_done;
   logic [2*WIDTH-1:0] mul_prod;

   logic [WIDTH-1:0] out_q;
   logic [WIDTH-1:0] out_hi_q;
   alu_flags_t       flags_q;
   logic             out_valid_q;

   logic [WIDTH-1:0] alu_res;
   alu_flags_t       alu_fl;
   alu_flags_t       mul_fl;

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [SHW-1:0]   s_amt;
   logic [WIDTH-1:0] shr_t;
   logic [WIDTH-1:0] shl_t;

   assign op = alu_op_t'(ALU_Sel);

   alu_mul_seq #(
      .WIDTH (WIDTH),
      .SHW   (SHW)
   ) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start),
      .a       (A),
      .b       (B),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_prod)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next state: leave IDLE only for MUL, return when the multiplier finishes.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (mul_start) state_nxt = S_MUL;
         S_MUL:   if (mul_done || !mul_busy) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // FSM outputs: handshake and load strobes. A stalled result blocks new work.
   always_comb begin
      in_ready  = !rst && (state == S_IDLE) && (!out_valid_q || out_ready);
      accept    = in_valid && in_ready;
      load_alu  = accept && (op != OP_MUL);
      mul_start = accept && (op == OP_MUL);
      load_mul  = (state == S_MUL) && mul_done;
   end

   // Single-cycle datapath: all non-MUL ops and their flags.
   always_comb begin
      sum    = {1'b0, A} + {1'b0, B};
      diff   = {1'b0, A} - {1'b0, B};
      s_amt  = B[SHW-1:0];
      // Shifting by s-1 puts the last bit shifted out at the edge; ignored when s == 0.
      shr_t  = A >> (s_amt - SHW'(1));
      shl_t  = A << (s_amt - SHW'(1));
      alu_res = '0;
      alu_fl  = FLAGS_CLR;
      case (op)
         OP_ADD: begin
            alu_res     = sum[WIDTH-1:0];
            alu_fl.cout = sum[WIDTH];
            alu_fl.ovf  = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res     = diff[WIDTH-1:0];
            alu_fl.cout = diff[WIDTH];
            alu_fl.ovf  = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
         end
         OP_AND: alu_res = A & B;
         OP_OR:  alu_res = A | B;
         OP_XOR: alu_res = A ^ B;
         OP_SHR: begin
            alu_res     = A >> s_amt;
            alu_fl.cout = (s_amt != '0) && shr_t[0];
         end
         OP_SHL: begin
            alu_res     = A << s_amt;
            alu_fl.cout = (s_amt != '0) && shl_t[WIDTH-1];
         end
         default: alu_res = '0;
      endcase
      alu_fl.zero = (alu_res == '0);
      alu_fl.neg  = alu_res[WIDTH-1];
   end

   // MUL flags: zero looks at the whole double-width product.
   always_comb begin
      mul_fl      = FLAGS_CLR;
      mul_fl.cout = (mul_prod[2*WIDTH-1:WIDTH] != '0);
      mul_fl.zero = (mul_prod == '0);
      mul_fl.neg  = mul_prod[WIDTH-1];
   end

   // Result registers: load on accept or multiplier completion, otherwise hold until consumed.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_q       <= '0;
         out_hi_q    <= '0;
         flags_q     <= FLAGS_CLR;
         out_valid_q <= 1'b0;
      end else if (load_alu) begin
         out_q       <= alu_res;
         out_hi_q    <= '0;
         flags_q     <= alu_fl;
         out_valid_q <= 1'b1;
      end else if (load_mul) begin
         out_q       <= mul_prod[WIDTH-1:0];
         out_hi_q    <= mul_prod[2*WIDTH-1:WIDTH];
         flags_q     <= mul_fl;
         out_valid_q <= 1'b1;
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign out_valid = out_valid_q;
   assign Out       = out_q;
   assign Out_hi    = out_hi_q;
   assign Cout      = flags_q.cout;
   assign Zero      = flags_q.zero;
   assign Neg       = flags_q.neg;
   assign Ovf       = flags_q.ovf;

endmodule
